// File: rtl/ixc_assign_arb.sv
// ixc_assign_arb: round-robin N:1 arbiter into a one-entry output buffer; burst locking compiled only under IXC_ASSIGN_ARB_LOCK_EN.
module ixc_assign_arb #(
    parameter int W = 14,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    input  logic [N*W-1:0] req_data,
    input  logic [N-1:0]   req_lock,
    output logic [N-1:0]   req_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic [2:0]     out_src,
    input  logic           out_ready
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t state, state_nx;
    logic [2:0] ptr, win;
    logic [N-1:0] elig;
    logic [W-1:0] sel_data;
    logic found, slot_open, accept;
    int idx;
`ifdef IXC_ASSIGN_ARB_LOCK_EN
    logic locked;
    logic [2:0] owner;
    assign elig = locked ? req_valid & (N'(1) << owner) : req_valid;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            locked <= 1'b0;
            owner  <= '0;
        end else if (accept) begin
            locked <= |(req_lock & req_ready);
            owner  <= win;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign elig = req_valid;
`endif
    // descending scan so the lowest offset from ptr is the last (winning) assignment
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            idx = idx >= N ? idx - N : idx;
            if (((elig >> idx) & N'(1)) != '0) begin
                win = 3'(idx);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++)
            if (3'(i) == win) sel_data = req_data[i*W +: W];
    end
    assign slot_open = !rst && (state == EMPTY || out_ready);
    assign accept    = slot_open && found;
    assign req_ready = accept ? N'(1) << win : '0;
    assign out_valid = state == FULL;
    always_comb state_nx = accept ? FULL : (out_ready ? EMPTY : state);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nx;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_src  <= '0;
            ptr      <= '0;
        end else if (accept) begin
            out_data <= sel_data;
            out_src  <= win;
            ptr      <= win == 3'(N - 1) ? 3'd0 : win + 3'd1;
        end
    end
endmodule

// File: tb/tb_ixc_assign_arb.sv
// tb_ixc_assign_arb: randomized and directed checks of ixc_assign_arb against a queue-free behavioural model.
module tb_ixc_assign_arb;
    localparam int W = 14;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_lock = '0;
    logic [N*W-1:0] req_data = '0;
    logic out_ready = 1'b0;
    logic [N-1:0] req_ready;
    logic out_valid;
    logic [W-1:0] out_data;
    logic [2:0] out_src;
    int total = 0;
    int bad = 0;
    bit m_full;
    logic [W-1:0] m_data;
    int m_src, m_ptr, m_owner;
    bit m_locked;
    int waitc [N];

    ixc_assign_arb #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock),
        .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // first eligible requester walking forward from the pointer, or -1
    function automatic int pick(input logic [N-1:0] v);
        logic [N-1:0] el;
        el = m_locked ? v & (N'(1) << m_owner) : v;
        for (int o = 0; o < N; o++) begin
            logic [1:0] k;
            k = 2'((m_ptr + o) % N);
            if (el[k]) return int'(k);
        end
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '1;
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_src", out_src, 0);
        check("rst_ready", req_ready, 0);
        m_full = 0; m_ptr = 0; m_src = 0; m_data = '0; m_locked = 0; m_owner = 0;
        for (int k = 0; k < N; k++) waitc[k] = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic step(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic [N-1:0] lk, input logic ordy);
        int w;
        req_valid = v; req_data = d; req_lock = lk; out_ready = ordy;
        #2;
        w = (!m_full || ordy) ? pick(v) : -1;
        check("req_ready", req_ready, w < 0 ? 0 : 1 << w);
        check("out_valid", out_valid, m_full);
        if (m_full) begin
            check("out_data", out_data, m_data);
            check("out_src", out_src, m_src);
        end
`ifndef IXC_ASSIGN_ARB_LOCK_EN
        for (int k = 0; k < N; k++) begin
            if (!v[k]) waitc[k] = 0;
            else if (w >= 0) waitc[k] = (k == w) ? 0 : waitc[k] + 1;
            if (v[k] && w >= 0) check("fair", waitc[k] <= N - 1, 1);
        end
`endif
        @(posedge clk);
        if (w >= 0) begin
            m_full = 1;
            m_data = d[w*W +: W];
            m_src = w;
            m_ptr = (w + 1) % N;
`ifdef IXC_ASSIGN_ARB_LOCK_EN
            m_locked = lk[w];
            m_owner = w;
`endif
        end else if (ordy) m_full = 0;
        #1;
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] held_d;
        logic [2:0] held_s;
        #2;
        do_reset();
        step(4'b0001, {42'h0, 14'h1ABC}, '0, 1'b1);
        check("single_valid", out_valid, 1);
        check("single_data", out_data, 14'h1ABC);
        check("single_src", out_src, 0);
        step('0, rnd_data(), '0, 1'b1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(4'hF, rnd_data(), '0, 1'b1);
            check("rr_seq", out_src, i % 4);
        end
        held_d = out_data;
        held_s = out_src;
        for (int i = 0; i < 5; i++) begin
            step(N'($urandom), rnd_data(), '0, 1'b0);
            check("hold_data", out_data, held_d);
            check("hold_src", out_src, held_s);
            check("hold_valid", out_valid, 1);
        end
        do_reset();
        step(4'b0010, rnd_data(), '0, 1'b1);
        step(4'b1010, rnd_data(), '0, 1'b1);
        check("ptr2_first", out_src, 3);
        step(4'b1010, rnd_data(), '0, 1'b1);
        check("ptr2_second", out_src, 1);
        step(4'b0001, {42'h0, 14'h3FFF}, '0, 1'b1);
        check("pre_rst_data", out_data, 14'h3FFF);
        req_valid = '0;
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_data", out_data, 0);
        do_reset();
`ifdef IXC_ASSIGN_ARB_LOCK_EN
        step(4'b0010, rnd_data(), '0, 1'b1);
        step(4'b0111, rnd_data(), 4'b0100, 1'b1);
        check("lock_b0", out_src, 2);
        step(4'b0111, rnd_data(), 4'b0100, 1'b1);
        check("lock_b1", out_src, 2);
        step(4'b0111, rnd_data(), 4'b0000, 1'b1);
        check("lock_b2", out_src, 2);
        step(4'b0011, rnd_data(), '0, 1'b1);
        check("unlock_0", out_src, 0);
        step(4'b0011, rnd_data(), '0, 1'b1);
        check("unlock_1", out_src, 1);
        do_reset();
`endif
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            step(N'($urandom), rnd_data(), N'($urandom & $urandom), $urandom_range(0, 3) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ixc_assign_arb.md
IXC_ASSIGN_ARB -- requirements
Module: ixc_assign_arb

Interface
- REQ-001 SHALL have parameter W, default 14, data width of each requester and of the shared output path.
- REQ-002 SHALL have parameter N, default 4, number of requesters; legal values 2..8.
- REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
- REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
- REQ-005 SHALL have port req_valid  input  N  per-requester valid.
- REQ-006 SHALL have port req_data  input  N*W  packed data; requester k occupies bits [k*W +: W].
- REQ-007 SHALL have port req_lock  input  N  per-requester burst-lock qualifier (see Configuration).
- REQ-008 SHALL have port req_ready  output  N  one-hot (or zero) acceptance strobe.
- REQ-009 SHALL have port out_valid  output  1  shared path holds a valid beat.
- REQ-010 SHALL have port out_data  output  W  beat payload.
- REQ-011 SHALL have port out_src  output  3  index of the requester that supplied the beat.
- REQ-012 SHALL have port out_ready  input  1  downstream acceptance.

Function
- REQ-013 SHALL implement a one-entry output buffer with states EMPTY and FULL; out_valid is 1 exactly in FULL.
- REQ-014 SHALL define the slot as open when state is EMPTY, or when state is FULL and out_ready=1.
- REQ-015 SHALL, when the slot is open and any req_valid=1, select the winner by round-robin: first set req_valid bit at or after pointer ptr, wrapping modulo N.
- REQ-016 SHALL assert req_ready combinationally only for the winner, only while the slot is open; all other bits 0.
- REQ-017 SHALL, on a cycle where req_valid[k] and req_ready[k] are both 1, load out_data from requester k's data, set out_src=k, enter FULL, and set ptr=(k+1) mod N.
- REQ-018 SHALL give one-cycle latency: a beat accepted at edge N is visible on out_* after edge N.
- REQ-019 SHALL, in FULL with out_ready=1 and no req_valid, return to EMPTY.
- REQ-020 SHALL, in FULL with out_ready=1 and a winner present, reload in the same cycle and remain FULL, sustaining one beat per cycle.
- REQ-021 SHALL hold out_data, out_src, and out_valid stable while FULL and out_ready=0.
- REQ-022 SHALL leave ptr unchanged on cycles with no acceptance.
- REQ-023 SHALL guarantee that no requester holding req_valid waits more than N-1 grants to others (lock disabled).

Reset
- REQ-024 SHALL, while rst=1, force state=EMPTY, out_valid=0, out_data=0, out_src=0, ptr=0, and lock state cleared, independent of clk.
- REQ-025 SHALL drive req_ready=0 while rst=1.
- REQ-026 SHALL discard any beat held in the buffer when reset is asserted mid-operation; no partial output after reset release.

Configuration
- REQ-027 SHALL compile burst locking only when macro IXC_ASSIGN_ARB_LOCK_EN is defined.
- REQ-028 SHALL, with IXC_ASSIGN_ARB_LOCK_EN defined, latch lock owner k when requester k's beat is accepted with req_lock[k]=1. While locked, only requester k is eligible and others are masked even if valid. Lock releases when k's beat is accepted with req_lock[k]=0.
- REQ-029 SHALL, without IXC_ASSIGN_ARB_LOCK_EN, keep port req_lock present but ignore it, with no lock state.

Verification
- REQ-030 SHALL cover: reset, then req_valid=4'b0001, data0=14'h1ABC, out_ready=1 -> req_ready=0001 same cycle; next cycle out_valid=1, out_data=14'h1ABC, out_src=0.
- REQ-031 SHALL cover: all four valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0, one beat per cycle.
- REQ-032 SHALL cover: FULL with out_ready=0 for 5 cycles, inputs changing -> out_* constant, req_ready=0000 throughout.
- REQ-033 SHALL cover: req_valid=4'b1010 with ptr=2 -> grant 3 first, then 1.
- REQ-034 SHALL cover: rst pulsed while FULL with out_data=14'h3FFF -> out_valid=0, out_data=0 immediately, before any clk edge.
- REQ-035 SHALL cover, with LOCK_EN: requester 2 sends 3 beats with lock=1,1,0 while 0 and 1 are valid -> out_src=2,2,2, then 3-wrap order resumes (0, then 1).
